spi_rx_deser: RTL and testbench

Serial-to-parallel receiver for the SPI input pins. It sits directly downstream of the pad ring and consumes the padded `spi_fsI` / `spi_dataI` signals. It assembles MSB-first frames into WORD_W-bit words and buffers them in a small FIFO. Words are handed to the DSP core over a valid/ready interface, with sticky framing and overflow error flags.

---
 rtl/spi_rx_pkg.sv | 18 +
 rtl/spi_rx_fifo.sv | 55 +++++
 rtl/spi_rx_deser.sv | 125 ++++++++++++
 tb/tb_spi_rx_deser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the SPI
// receive deserializer.
package spi_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int WORD_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PTR_W_DEF      = $clog2(FIFO_DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Word FIFO between the deserializer and the core.
// Wrap-bit pointers tell full from empty.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[PW-1:0]] <= wdata;
        wptr <= wptr + (PW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spi_rx_deser.sv
// SPI serial-to-parallel receiver: frame FSM,
// shift register, sticky error flags and word FIFO.
module spi_rx_deser
  import spi_rx_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_fsI,
  input  logic              spi_dataI,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W-1);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [CNT_W-1:0]  bitcnt_d;
  logic [WORD_W-2:0] shreg_q;
  logic [WORD_W-2:0] shreg_d;
  logic              ferr_q;
  logic              ferr_d;
  logic              ovf_q;
  logic              ovf_d;

  logic              last;
  logic              push;
  logic              abort;
  logic [WORD_W-1:0] word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              ovf_set;

  assign last = (state_q == SHIFT) && (bitcnt_q == LAST);
  assign word = {shreg_q, spi_dataI};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spi_fsI) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          push     = 1'b1;
          bitcnt_d = '0;
          shreg_d  = word[WORD_W-2:0];
          // fs on the final bit chains straight into the next frame.
          if (!spi_fsI) begin
            state_d = IDLE;
          end
        end else if (spi_fsI) begin
          abort    = 1'b1;
          bitcnt_d = '0;
        end else begin
          shreg_d  = word[WORD_W-2:0];
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;
  assign ovf_set  = push && fifo_full && !pop;

  assign ferr_d = abort   || (ferr_q && !err_clr);
  assign ovf_d  = ovf_set || (ovf_q  && !err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

  spi_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (rx_data),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spi_rx_deser.sv
// Randomized bench for spi_rx_deser against a
// transaction-level queue model.
module tb_spi_rx_deser;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk;
  logic         reset;
  logic         spi_fsI;
  logic         spi_dataI;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         err_clr;
  logic         frame_err;
  logic         overflow;
  logic         busy;

  spi_rx_deser #(
    .WORD_W     (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_fsI   (spi_fsI),
    .spi_dataI (spi_dataI),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [W-1:0] mq [$];
  logic m_ferr;
  logic m_ovf;
  logic m_busy;

  int ready_mode;
  bit rdy_on_push;
  bit clr_req;
  bit rand_clr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic check_outputs();
    chk("valid", 32'(rx_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("data", 32'(rx_data), 32'(mq[0]));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input logic fs, input logic d,
                     input bit ev_push, input logic [W-1:0] w,
                     input bit ev_abort, input bit busy_nx);
    bit pop;
    bit ovf_set;
    int sz;
    if (rand_clr && ($urandom % 16 == 0)) clr_req = 1'b1;
    spi_fsI   = fs;
    spi_dataI = d;
    err_clr   = clr_req;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = rbit();
    endcase
    if (rdy_on_push) rx_ready = ev_push;
    sz  = mq.size();
    pop = (sz > 0) && rx_ready;
    ovf_set = 1'b0;
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (ev_push) begin
      if (sz < DEPTH || pop) mq.push_back(w);
      else ovf_set = 1'b1;
    end
    m_ovf  = ovf_set || (m_ovf && !clr_req);
    m_ferr = ev_abort || (m_ferr && !clr_req);
    m_busy = busy_nx;
    clr_req = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, rbit(), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fs_cycle();
    cyc(1'b1, rbit(), 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [W-1:0] w,
                            input int abort_after,
                            input bit fs_on_last);
    logic [W-1:0] v;
    bit lst;
    v = w;
    for (int j = 0; j < W; j++) begin
      if (j == abort_after) begin
        cyc(1'b1, rbit(), 1'b0, '0, 1'b1, 1'b1);
        return;
      end
      lst = (j == W-1);
      cyc(lst && fs_on_last, v[W-1-j], lst, v, 1'b0,
          !lst || fs_on_last);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit linked;
    bit b2b;
    int ab;
    n_chk = 0;
    n_fail = 0;
    ready_mode = 0;
    rdy_on_push = 1'b0;
    clr_req = 1'b0;
    rand_clr = 1'b0;
    reset = 1'b0;
    spi_fsI = 1'b0;
    spi_dataI = 1'b0;
    rx_ready = 1'b0;
    err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // single frame, then pop
    fs_cycle();
    send_frame(16'hA5C3, -1, 1'b0);
    chk("single_word", 32'(rx_data), 32'h0000A5C3);
    ready_mode = 1;
    idle(2);

    // back-to-back frames
    fs_cycle();
    send_frame(16'h1234, -1, 1'b1);
    send_frame(16'hFFFF, -1, 1'b1);
    send_frame(16'h0001, -1, 1'b0);
    idle(3);

    // early fs aborts a frame
    fs_cycle();
    send_frame(16'h5A5A, 7, 1'b0);
    send_frame(16'h8001, -1, 1'b0);
    idle(3);
    clr_req = 1'b1;
    idle(1);

    // overflow with core stalled
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      fs_cycle();
      send_frame(W'(i), -1, 1'b0);
      idle(1);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    clr_req = 1'b1;
    idle(1);
    ready_mode = 1;
    idle(DEPTH + 2);

    // full FIFO with pop exactly on the push cycle
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      fs_cycle();
      send_frame(W'(i), -1, 1'b0);
    end
    rdy_on_push = 1'b1;
    fs_cycle();
    send_frame(W'(4), -1, 1'b0);
    rdy_on_push = 1'b0;
    chk("full_pop_no_ovf", 32'(overflow), 32'd0);
    ready_mode = 1;
    idle(DEPTH + 2);

    // reset mid-frame with words queued
    ready_mode = 0;
    fs_cycle();
    send_frame(16'h1111, -1, 1'b0);
    fs_cycle();
    send_frame(16'h2222, -1, 1'b0);
    fs_cycle();
    send_frame(16'h3333, 9, 1'b0);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    idle(2);
    fs_cycle();
    send_frame(16'h00FF, -1, 1'b0);
    ready_mode = 1;
    idle(2);

    // randomized traffic
    ready_mode = 2;
    rand_clr = 1'b1;
    linked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ab = ($urandom % 6 == 0) ? int'($urandom_range(0, W-2)) : -1;
      b2b = (ab < 0) && ($urandom % 3 == 0);
      if (!linked) begin
        idle(int'($urandom_range(0, 3)));
        fs_cycle();
      end
      send_frame(W'($urandom), ab, b2b);
      linked = (ab >= 0) || b2b;
    end
    if (linked) send_frame(W'($urandom), -1, 1'b0);
    rand_clr = 1'b0;
    ready_mode = 1;
    idle(DEPTH + 2);
    chk("drained", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
